// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and coordinate/address types.
package vga_pkg;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int COORD_W_DEF = 10;
  localparam int ADDR_W_DEF  = 32;

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [ADDR_W_DEF-1:0]  addr_t;
endpackage

// File: rtl/vga_row_mult.sv
// Row start in pixels, y * H_RES, truncated to ADDR_W bits.
// Purely combinational. No handshake of its own.
module vga_row_mult #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 32,
  parameter int H_RES   = 640
) (
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  row
);
  // H_RES is a constant, so synthesis reduces this to a few shift-adds.
  assign row = ADDR_W'(y) * ADDR_W'(H_RES);
endmodule

// File: rtl/vga_gen_address.sv
// Pixel (x,y) to framebuffer byte address, 2 enabled edges of latency; en=0 freezes all state.
// GEN_ADDRESS_CLAMP_EN clamps x/y to the visible area before the address math (oob still uses raw inputs).
module vga_gen_address
  import vga_pkg::*;
#(
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PIX_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [ADDR_W-1:0]  offset,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  output logic               oob
);
  logic               x_oob, y_oob;
  logic [COORD_W-1:0] x_use, y_use;
  logic [ADDR_W-1:0]  row;

  logic [ADDR_W-1:0]  row_q, row_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0]  off_q, off_d;
  logic               vld1_q, vld1_d;
  logic               oob1_q, oob1_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               addr_valid_q, addr_valid_d;
  logic               oob_q, oob_d;

  assign x_oob = ADDR_W'(x) >= ADDR_W'(H_RES);
  assign y_oob = ADDR_W'(y) >= ADDR_W'(V_RES);

`ifdef GEN_ADDRESS_CLAMP_EN
  assign x_use = x_oob ? COORD_W'(H_RES - 1) : x;
  assign y_use = y_oob ? COORD_W'(V_RES - 1) : y;
`else
  assign x_use = x;
  assign y_use = y;
`endif

  vga_row_mult #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .H_RES   (H_RES)
  ) u_row_mult (
    .y   (y_use),
    .row (row)
  );

  always_comb begin
    row_d        = row_q;
    x_d          = x_q;
    off_d        = off_q;
    vld1_d       = vld1_q;
    oob1_d       = oob1_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    oob_d        = oob_q;
    if (en) begin
      row_d        = row;
      x_d          = x_use;
      off_d        = offset;
      vld1_d       = 1'b1;
      oob1_d       = x_oob | y_oob;
      // Out-of-range coordinates still get an address; only the flags differ.
      addr_d       = off_q + ((row_q + ADDR_W'(x_q)) << PIX_SHIFT);
      addr_valid_d = vld1_q & ~oob1_q;
      oob_d        = vld1_q & oob1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      x_q          <= '0;
      off_q        <= '0;
      vld1_q       <= 1'b0;
      oob1_q       <= 1'b0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      row_q        <= row_d;
      x_q          <= x_d;
      off_q        <= off_d;
      vld1_q       <= vld1_d;
      oob1_q       <= oob1_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      oob_q        <= oob_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign oob        = oob_q;
endmodule

// File: tb/tb_vga_gen_address.sv
// Directed bench for vga_gen_address with hand-computed addresses.
module tb_vga_gen_address;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [9:0]  x   = '0;
  logic [9:0]  y   = '0;
  logic [31:0] offset = '0;
  logic [31:0] addr;
  logic        addr_valid;
  logic        oob;

  int total = 0;
  int bad   = 0;

  logic        have_prev = 1'b0;
  string       prev_tag;
  logic [31:0] prev_a;
  logic        prev_v, prev_o;

  always #5 clk = ~clk;

  vga_gen_address dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .x          (x),
    .y          (y),
    .offset     (offset),
    .addr       (addr),
    .addr_valid (addr_valid),
    .oob        (oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [31:0] a, input logic v, input logic o);
    chk({tag, ".addr"}, addr, a);
    chk({tag, ".vld"}, 32'(addr_valid), 32'(v));
    chk({tag, ".oob"}, 32'(oob), 32'(o));
  endtask

  // Drive one coordinate; outputs after the edge belong to the previous one.
  task automatic stream(input string tag, input int xi, input int yi, input logic [31:0] off,
                        input logic [31:0] ea, input logic ev, input logic eo);
    x = 10'(xi);
    y = 10'(yi);
    offset = off;
    tick();
    if (have_prev) chk3(prev_tag, prev_a, prev_v, prev_o);
    have_prev = 1'b1;
    prev_tag = tag;
    prev_a = ea;
    prev_v = ev;
    prev_o = eo;
  endtask

  task automatic flush();
    x = 10'd77;
    y = 10'd33;
    offset = 32'h5555_0000;
    tick();
    if (have_prev) chk3(prev_tag, prev_a, prev_v, prev_o);
    have_prev = 1'b0;
  endtask

  initial begin
    logic [31:0] a_x640, a_y480, a_big;
`ifdef GEN_ADDRESS_CLAMP_EN
    a_x640 = 32'h0000_09FC;
    a_y480 = 32'h0012_B600;
    a_big  = 32'h0012_BFFC;
`else
    a_x640 = 32'h0000_0A00;
    a_y480 = 32'h0012_C000;
    a_big  = 32'h0028_05FC;
`endif

    // Reset with enable high and junk inputs.
    rst = 1'b1; en = 1'b1; x = 10'd123; y = 10'd45; offset = 32'hDEAD_BEEF;
    tick();
    chk3("rst0", 32'h0, 1'b0, 1'b0);
    tick();
    chk3("rst1", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    stream("p00", 0, 0, 32'h0, 32'h0, 1'b1, 1'b0);
    stream("p01", 0, 1, 32'h0, 32'hA00, 1'b1, 1'b0);
    stream("p10", 1, 0, 32'h0, 32'h4, 1'b1, 1'b0);
    stream("row0", 0, 0, 32'h39C, 32'h39C, 1'b1, 1'b0);
    stream("row1", 0, 1, 32'h39C, 32'hD9C, 1'b1, 1'b0);
    stream("row2", 0, 2, 32'h39C, 32'h179C, 1'b1, 1'b0);
    stream("row3", 0, 3, 32'h39C, 32'h219C, 1'b1, 1'b0);
    stream("row4", 0, 4, 32'h39C, 32'h2B9C, 1'b1, 1'b0);
    stream("row_x1", 1, 0, 32'h39C, 32'h3A0, 1'b1, 1'b0);
    stream("last", 639, 479, 32'h0, 32'h12BFFC, 1'b1, 1'b0);
    stream("x640", 640, 0, 32'h0, a_x640, 1'b0, 1'b1);
    stream("y480", 0, 480, 32'h0, a_y480, 1'b0, 1'b1);
    stream("big", 1023, 1023, 32'h0, a_big, 1'b0, 1'b1);
    stream("wrap", 1, 0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    flush();

    // Enable stall: A then B, hold 3 cycles, resume with C.
    x = 10'd5; y = 10'd2; offset = 32'h100;
    tick();
    x = 10'd7; y = 10'd3; offset = 32'h0;
    tick();
    chk3("stallA", 32'h1514, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = 10'(700 + i); y = 10'(i * 9); offset = 32'h1234_0000;
      tick();
      chk3("hold", 32'h1514, 1'b1, 1'b0);
    end
    en = 1'b1;
    x = 10'd0; y = 10'd0; offset = 32'h40;
    tick();
    chk3("resumeB", 32'h1E1C, 1'b1, 1'b0);
    x = 10'd640; y = 10'd0; offset = 32'h0;
    tick();
    chk3("resumeC", 32'h40, 1'b1, 1'b0);

    // Mid-stream reset discards the in-flight coordinate.
    x = 10'd2; y = 10'd0; offset = 32'h0;
    tick();
    x = 10'd3; rst = 1'b1;
    tick();
    chk3("mrst", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    x = 10'd4;
    tick();
    chk3("mrst_bubble", 32'h0, 1'b0, 1'b0);
    x = 10'd5;
    tick();
    chk3("mrst_resume", 32'h10, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_gen_address.md
Name: vga_gen_address

Overview:
- Converts a VGA pixel coordinate (x, y) into a byte address in a linear, row-major framebuffer located at a programmable base (offset).
- Sits between the VGA timing counters and the framebuffer memory read port.
- Registered two-stage pipeline with a pipeline enable; flags coordinates outside the visible area.

Parameters:
- H_RES, 640, pixels per row; the row stride in pixels.
- V_RES, 480, number of visible rows; used only for bounds checking.
- COORD_W, 10, width of x and y.
- ADDR_W, 32, width of offset and addr.
- PIX_SHIFT, 2, log2 of bytes per pixel (2 means 4-byte word per pixel).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline enable; advances both stages when 1, holds all state when 0.
- x  in  COORD_W  pixel column.
- y  in  COORD_W  pixel row.
- offset  in  ADDR_W  framebuffer base byte address.
- addr  out  ADDR_W  computed byte address.
- addr_valid  out  1  addr corresponds to an in-range coordinate sampled with en=1.
- oob  out  1  sampled coordinate had x >= H_RES or y >= V_RES.

Behaviour:
- Function: addr = offset + ((y * H_RES + x) << PIX_SHIFT).
  - Arithmetic is unsigned and computed at ADDR_W bits.
  - Sum wraps modulo 2^ADDR_W; no saturation.
- Stage 1 (on en=1) registers:
  - row = y * H_RES, at ADDR_W bits;
  - x, offset;
  - valid bit set to 1;
  - oob bit = (x >= H_RES) || (y >= V_RES).
- Stage 2 (on en=1) registers:
  - addr = offset_s1 + ((row + x_s1) << PIX_SHIFT);
  - addr_valid = valid_s1 & ~oob_s1;
  - oob = valid_s1 & oob_s1.
- Latency: exactly 2 enabled clock edges from input sample to output.
- en=0: no register changes; addr, addr_valid and oob hold their last values. Inputs presented while en=0 are ignored.
- Reset (rst=1 at a clock edge):
  - all stage registers clear: addr=0, addr_valid=0, oob=0, internal valid bits 0;
  - rst has priority over en;
  - reset mid-stream discards any in-flight coordinate.
- Out-of-range coordinate:
  - addr is still computed by the same formula, with no clamping;
  - addr_valid=0, oob=1.
- Boundaries:
  - x=H_RES-1, y=V_RES-1 is the last valid pixel;
  - x=H_RES or y=V_RES is the first oob value.
- Multiplier: H_RES is a constant, so shift-add or inferred multiply are both acceptable.

Optional Feature:
- Macro GEN_ADDRESS_CLAMP_EN.
- When defined, stage 1 clamps coordinates before use:
  - x is replaced by min(x, H_RES-1);
  - y is replaced by min(y, V_RES-1);
  - the oob flag is still computed from the raw inputs;
  - addr_valid follows the raw-input oob, so it is 0 for an out-of-range coordinate.
- When undefined, there is no clamping, as described in Behaviour.

Decomposition:
- Shared package vga_pkg holds:
  - constants H_RES_DEF=640, V_RES_DEF=480, COORD_W_DEF=10, ADDR_W_DEF=32;
  - typedefs coord_t (logic [9:0]) and addr_t (logic [31:0]).
- One natural sub-module, vga_row_mult: constant multiply y*H_RES, combinational, instantiated in stage 1.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and arbitrary inputs -> addr=0, addr_valid=0, oob=0.
- Basic mapping: en=1, offset=0x0, (x,y)=(0,0),(0,1),(1,0) on consecutive cycles -> 2 cycles later addr=0x0, 0xA00, 0x4, each with addr_valid=1.
- Offset plus row sweep: offset=0x39C, x=0, y=0..4 -> addr=0x39C, 0xD9C, 0x179C, 0x219C, 0x2B9C; then x=1, y=0 -> 0x3A0.
- Last pixel and bounds:
  - offset=0, (639,479) -> addr=0x12BFFC, addr_valid=1;
  - (640,0) -> oob=1, addr_valid=0, addr=0xA00 (clamp off) or 0x9FC (GEN_ADDRESS_CLAMP_EN).
- Enable stall: drop en for 3 cycles while changing x,y -> outputs frozen; on re-enable the pipeline resumes from the held state with no lost or duplicated sample.
- Wrap and mid-stream reset:
  - offset=0xFFFFFFFC, (1,0) -> addr=0x0;
  - assert rst for 1 cycle mid-stream -> next outputs 0 / invalid until 2 enabled cycles later.
